// File: rtl/snell_pkg.sv
// Shared constants and result record for the comp unit, its scheduler and their benches.
package snell_pkg;

    localparam int unsigned XW       = 7;
    localparam int unsigned YW       = 8;
    localparam int unsigned COMP_LAT = 1;
    localparam int unsigned ID_MAX_W = 3;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [YW-1:0]       y;
    } comp_rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO; head entry and valid come straight from registers, so there is no write-to-read bypass.
module sync_fifo #(
    parameter int unsigned W     = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic         rd_valid,
    output logic [W-1:0] rd_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   count;
    logic          pop;
    logic          full;

    assign pop      = rd_en && (count != '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign rd_valid = (count != '0);
    assign rd_data  = mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wp] <= wr_data;
                wp      <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            if (wr_en && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (!wr_en && pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    // The scheduler's credit limit guarantees room for every write.
    assert property (@(posedge clk) disable iff (rst) !(wr_en && full));

endmodule

// File: rtl/comp_sched.sv
// Round-robin scheduler sharing one fixed-latency comp unit among NREQ requesters, with tagged in-order results.
module comp_sched
    import snell_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned XW       = snell_pkg::XW,
    parameter int unsigned YW       = snell_pkg::YW,
    parameter int unsigned COMP_LAT = snell_pkg::COMP_LAT,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*XW-1:0]      req_x,
    output logic [NREQ-1:0]         req_ready,
    output logic [XW-1:0]           comp_x,
    input  logic [YW-1:0]           comp_y,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [YW-1:0]           rsp_y,
    input  logic                    rsp_ready
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(DEPTH + 1);

    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    gidx;
    logic [CW-1:0]     cnt;
    logic              issue_ok;
    logic              issue;
    logic              pop;
    logic [COMP_LAT:0] tag_v;
    logic [IDW-1:0]    tag_id [COMP_LAT+1];
    logic [IDW+YW-1:0] head;

    assign issue_ok = !rst && (cnt < CW'(DEPTH));
    assign issue    = |req_ready;
    assign pop      = rsp_valid && rsp_ready;

    // Scan offsets from farthest to nearest so the nearest valid requester overwrites.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        req_ready = '0;
        gidx      = '0;
        if (issue_ok) begin
            for (int unsigned k = NREQ; k > 0; k--) begin
                idx = 32'(ptr) + k - 1;
                if (idx >= NREQ) begin
                    idx = idx - NREQ;
                end
                if (req_valid[IDW'(idx)]) begin
                    req_ready             = '0;
                    req_ready[IDW'(idx)]  = 1'b1;
                    gidx                  = IDW'(idx);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            comp_x <= '0;
            cnt    <= '0;
            tag_v  <= '0;
            for (int unsigned i = 0; i <= COMP_LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            if (issue) begin
                comp_x <= req_x[32'(gidx)*XW +: XW];
                ptr    <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
            end
            if (issue && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (!issue && pop) begin
                cnt <= cnt - CW'(1);
            end
            tag_v     <= {tag_v[COMP_LAT-1:0], issue};
            tag_id[0] <= gidx;
            for (int unsigned i = 1; i <= COMP_LAT; i++) begin
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    sync_fifo #(
        .W     (IDW + YW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (tag_v[COMP_LAT]),
        .wr_data  ({tag_id[COMP_LAT], comp_y}),
        .rd_en    (rsp_ready),
        .rd_valid (rsp_valid),
        .rd_data  (head)
    );

    assign {rsp_id, rsp_y} = head;

endmodule
